add_num_csr: RTL and testbench
==============================

# add_num_csr

MMIO control/status register stage for the add-two-numbers CCI-P AFU. It sits between the host MMIO channel (c0 MMIO requests in, c2 MMIO responses out) and the add-num memory engine. It implements the device feature list, holds the source/destination cache-line addresses, issues a one-cycle start pulse to the engine, and captures the engine's result, status and job cycle count for host readback.

## Interface
Parameters:
- AFU_ID, 128'h0: AFU UUID returned at ID_L/ID_H.
- CL_ADDR_W, 42: cache-line address width.

Ports:
- clk  in  1  AFU clock.
- reset  in  1  synchronous, active-high.
- mmio_rd_valid  in  1  MMIO read request this cycle.
- mmio_wr_valid  in  1  MMIO write request this cycle.
- mmio_addr  in  16  MMIO address, 32-bit-word units.
- mmio_tid  in  9  read transaction ID.
- mmio_wr_data  in  64  write data.
- rsp_valid  out  1  MMIO read response valid.
- rsp_tid  out  9  echoed transaction ID.
- rsp_data  out  64  read data.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_src_addr  out  CL_ADDR_W  line holding the operands.
- eng_dst_addr  out  CL_ADDR_W  line the result is written to.
- eng_done  in  1  one-cycle pulse: engine finished its write.
- eng_result  in  16  sum, valid with eng_done.

## Operation
Register map (word address, 64-bit registers):
- 0x00 DFH, RO: [63:60]=4'h1, [40]=1, all other bits 0.
- 0x02 ID_L, RO: AFU_ID[63:0].
- 0x04 ID_H, RO: AFU_ID[127:64].
- 0x06, 0x08 RSVD, RO: 0.
- 0x0A SRC_ADDR, RW: [CL_ADDR_W-1:0].
- 0x0C DST_ADDR, RW: [CL_ADDR_W-1:0].
- 0x0E CTRL, WO: write with bit0=1 requests start. Reads return 0.
- 0x10 STATUS: [0] busy (RO), [1] done (sticky, write 1 to clear), [2] overrun (sticky, write 1 to clear).
- 0x12 RESULT, RO: [15:0] last eng_result, upper bits 0.
- 0x14 CYCLES, RO: [31:0] job cycle count.
- All other addresses read 0. Writes to them and to RO registers are ignored.

Behaviour:
- Writes: the low CL_ADDR_W bits of data go to SRC/DST. Data bits above that are dropped.
- Start request accepted only if busy=0:
  - eng_start=1 next cycle.
  - busy<=1, done<=0, CYCLES<=0.
  - SRC/DST are presented continuously on eng_src_addr/eng_dst_addr.
- Start request while busy=1: no pulse; overrun<=1.
- eng_done while busy=1: busy<=0, done<=1, RESULT<=eng_result.
- eng_done while busy=0: ignored entirely.
- CYCLES increments every cycle busy=1 and saturates at 32'hFFFF_FFFF.
- Simultaneous events:
  - Start request in the same cycle as eng_done: start is ignored and sets overrun, because busy is still 1 that cycle.
  - W1C of done in the same cycle eng_done sets it: set wins.
  - Read and write in the same cycle: both serviced. The read returns the pre-write value.
- SRC/DST writes while busy update the registers immediately. The engine must have latched its addresses at eng_start.

## Timing
- Read latency is exactly 1 cycle: rsp_valid=1 the cycle after mmio_rd_valid, with rsp_tid and rsp_data registered. One response per request; back-to-back reads are supported every cycle.
- eng_start is asserted the cycle after the accepting CTRL write and lasts exactly 1 cycle.
- STATUS/RESULT reflect eng_done from the next cycle.
- Reset values:
  - rsp_valid=0, rsp_tid=0, rsp_data=0.
  - eng_start=0.
  - SRC=DST=0.
  - busy=done=overrun=0, RESULT=0, CYCLES=0.
- Reset mid-job: busy clears, and a later eng_done is ignored.

## Structure
- Package add_num_csr_pkg holds:
  - register word-address localparams;
  - STATUS bit index constants;
  - DFH constant;
  - the t_add_num_status packed struct.
- One sub-module, add_num_sat_counter (width parameter; clear, enable, saturate), used for CYCLES.

## Test plan
- Read 0x00, 0x02, 0x04, 0x06 with tids 1-4 -> responses 1 cycle later with tids echoed; data 0x1000_0100_0000_0000, ID_L, ID_H, 0.
- Write SRC=0x1000, DST=0x2000, then CTRL=1 -> single eng_start pulse; eng_src_addr=0x1000; eng_dst_addr=0x2000; STATUS reads 0x1.
- With busy, wait 7 cycles then eng_done with eng_result=0x0046 -> STATUS=0x2, RESULT=0x46, CYCLES=8.
- CTRL=1 while busy, and CTRL=1 in the same cycle as eng_done -> no eng_start either time; STATUS overrun bit set; W1C of 0x6 clears done and overrun.
- eng_done with busy=0 -> RESULT and STATUS unchanged; assert reset mid-job -> all outputs at reset values; next CTRL start accepted.

Source files
------------

// File: rtl/add_num_csr_pkg.sv
// Shared constants and types for the add-num MMIO register stage:
// register word addresses, STATUS bit layout and the device feature header.
package add_num_csr_pkg;

  localparam logic [15:0] ADDR_DFH    = 16'h0000;
  localparam logic [15:0] ADDR_ID_L   = 16'h0002;
  localparam logic [15:0] ADDR_ID_H   = 16'h0004;
  localparam logic [15:0] ADDR_RSVD0  = 16'h0006;
  localparam logic [15:0] ADDR_RSVD1  = 16'h0008;
  localparam logic [15:0] ADDR_SRC    = 16'h000A;
  localparam logic [15:0] ADDR_DST    = 16'h000C;
  localparam logic [15:0] ADDR_CTRL   = 16'h000E;
  localparam logic [15:0] ADDR_STATUS = 16'h0010;
  localparam logic [15:0] ADDR_RESULT = 16'h0012;
  localparam logic [15:0] ADDR_CYCLES = 16'h0014;

  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_DONE_BIT    = 1;
  localparam int STATUS_OVERRUN_BIT = 2;
  localparam int STATUS_W           = 3;

  // AFU feature header: type [63:60]=1, end-of-list [40]=1.
  localparam logic [63:0] DFH_VALUE = 64'h1000_0100_0000_0000;

  // Member order places busy at bit 0, done at bit 1, overrun at bit 2.
  typedef struct packed {
    logic overrun;
    logic done;
    logic busy;
  } t_add_num_status;

endpackage

// File: rtl/add_num_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over enable.
module add_num_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/add_num_csr.sv
// MMIO register stage for the add-num AFU: feature header, address registers,
// start pulse generation and capture of the engine's result and job length.
module add_num_csr
  import add_num_csr_pkg::*;
#(
  parameter logic [127:0] AFU_ID    = 128'h0,
  parameter int           CL_ADDR_W = 42
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mmio_rd_valid,
  input  logic                 mmio_wr_valid,
  input  logic [15:0]          mmio_addr,
  input  logic [8:0]           mmio_tid,
  input  logic [63:0]          mmio_wr_data,
  output logic                 rsp_valid,
  output logic [8:0]           rsp_tid,
  output logic [63:0]          rsp_data,
  output logic                 eng_start,
  output logic [CL_ADDR_W-1:0] eng_src_addr,
  output logic [CL_ADDR_W-1:0] eng_dst_addr,
  input  logic                 eng_done,
  input  logic [15:0]          eng_result
);

  logic [CL_ADDR_W-1:0] src_addr;
  logic [CL_ADDR_W-1:0] dst_addr;
  t_add_num_status      status;
  logic [15:0]          result;
  logic [31:0]          cycles;
  logic [63:0]          rd_data;

  logic start_req;
  logic start_accept;
  logic done_evt;
  logic status_wr;
  logic unused_wr_bits;

  // Handshake: MMIO requests are single-cycle strobes with no backpressure;
  // each read strobe yields exactly one rsp_valid pulse one cycle later.
  assign start_req    = mmio_wr_valid && (mmio_addr == ADDR_CTRL) && mmio_wr_data[0];
  assign start_accept = start_req && !status.busy;
  assign done_evt     = eng_done && status.busy;
  assign status_wr    = mmio_wr_valid && (mmio_addr == ADDR_STATUS);

  assign unused_wr_bits = ^mmio_wr_data;

  assign eng_src_addr = src_addr;
  assign eng_dst_addr = dst_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_addr <= '0;
      dst_addr <= '0;
    end else if (mmio_wr_valid) begin
      if (mmio_addr == ADDR_SRC) src_addr <= mmio_wr_data[CL_ADDR_W-1:0];
      if (mmio_addr == ADDR_DST) dst_addr <= mmio_wr_data[CL_ADDR_W-1:0];
    end
  end

  // A start is only accepted when idle, so it can never coincide with done_evt.
  always_ff @(posedge clk) begin
    if (reset) begin
      status    <= '0;
      result    <= '0;
      eng_start <= 1'b0;
    end else begin
      eng_start <= start_accept;

      if (start_accept)  status.busy <= 1'b1;
      else if (done_evt) status.busy <= 1'b0;

      if (start_accept)  status.done <= 1'b0;
      else if (done_evt) status.done <= 1'b1;
      else if (status_wr && mmio_wr_data[STATUS_DONE_BIT]) status.done <= 1'b0;

      if (start_req && status.busy) status.overrun <= 1'b1;
      else if (status_wr && mmio_wr_data[STATUS_OVERRUN_BIT]) status.overrun <= 1'b0;

      if (done_evt) result <= eng_result;
    end
  end

  add_num_sat_counter #(
    .WIDTH(32)
  ) u_cycles (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_accept),
    .enable (status.busy),
    .count  (cycles)
  );

  always_comb begin
    rd_data = '0;
    case (mmio_addr)
      ADDR_DFH:    rd_data = DFH_VALUE;
      ADDR_ID_L:   rd_data = AFU_ID[63:0];
      ADDR_ID_H:   rd_data = AFU_ID[127:64];
      ADDR_SRC:    rd_data[CL_ADDR_W-1:0] = src_addr;
      ADDR_DST:    rd_data[CL_ADDR_W-1:0] = dst_addr;
      ADDR_STATUS: rd_data[STATUS_W-1:0] = status;
      ADDR_RESULT: rd_data[15:0] = result;
      ADDR_CYCLES: rd_data[31:0] = cycles;
      default:     rd_data = '0;
    endcase
  end

  // Registering from pre-edge state makes a same-cycle write invisible to the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_tid   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        rsp_tid  <= mmio_tid;
        rsp_data <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_add_num_csr.sv
// Bench for add_num_csr: directed scenarios plus randomized traffic, checked
// against a register-level reference model and an expected-response queue.
module tb_add_num_csr;

  localparam logic [127:0] AFU_ID    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam int           CL_ADDR_W = 42;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 mmio_rd_valid;
  logic                 mmio_wr_valid;
  logic [15:0]          mmio_addr;
  logic [8:0]           mmio_tid;
  logic [63:0]          mmio_wr_data;
  logic                 rsp_valid;
  logic [8:0]           rsp_tid;
  logic [63:0]          rsp_data;
  logic                 eng_start;
  logic [CL_ADDR_W-1:0] eng_src_addr;
  logic [CL_ADDR_W-1:0] eng_dst_addr;
  logic                 eng_done;
  logic [15:0]          eng_result;

  add_num_csr #(
    .AFU_ID    (AFU_ID),
    .CL_ADDR_W (CL_ADDR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mmio_rd_valid (mmio_rd_valid),
    .mmio_wr_valid (mmio_wr_valid),
    .mmio_addr     (mmio_addr),
    .mmio_tid      (mmio_tid),
    .mmio_wr_data  (mmio_wr_data),
    .rsp_valid     (rsp_valid),
    .rsp_tid       (rsp_tid),
    .rsp_data      (rsp_data),
    .eng_start     (eng_start),
    .eng_src_addr  (eng_src_addr),
    .eng_dst_addr  (eng_dst_addr),
    .eng_done      (eng_done),
    .eng_result    (eng_result)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // scoreboard
  logic [63:0] exp_q[$];
  logic [8:0]  exp_tid_q[$];

  // reference model state
  bit          m_busy, m_done, m_overrun, m_start;
  logic [15:0] m_result;
  logic [31:0] m_cycles;
  logic [41:0] m_src, m_dst;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [15:0] addr);
    case (addr)
      16'h00:  return 64'h1000_0100_0000_0000;
      16'h02:  return AFU_ID[63:0];
      16'h04:  return AFU_ID[127:64];
      16'h0A:  return {22'd0, m_src};
      16'h0C:  return {22'd0, m_dst};
      16'h10:  return {61'd0, m_overrun, m_done, m_busy};
      16'h12:  return {48'd0, m_result};
      16'h14:  return {32'd0, m_cycles};
      default: return 64'd0;
    endcase
  endfunction

  // Applies one clock of the register rules to the model, then checks the DUT.
  task automatic step();
    bit rd_exp, start_req, accept, done_evt, st_wr;
    rd_exp = mmio_rd_valid && !reset;
    if (rd_exp) begin
      exp_q.push_back(model_read(mmio_addr));
      exp_tid_q.push_back(mmio_tid);
    end
    if (reset) begin
      m_busy = 0; m_done = 0; m_overrun = 0; m_start = 0;
      m_result = '0; m_cycles = '0; m_src = '0; m_dst = '0;
    end else begin
      start_req = mmio_wr_valid && mmio_addr == 16'h0E && mmio_wr_data[0];
      accept    = start_req && !m_busy;
      done_evt  = eng_done && m_busy;
      st_wr     = mmio_wr_valid && mmio_addr == 16'h10;
      m_start   = accept;
      if (accept) m_cycles = 0;
      else if (m_busy && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
      if (start_req && m_busy) m_overrun = 1;
      else if (st_wr && mmio_wr_data[2]) m_overrun = 0;
      if (accept) m_done = 0;
      else if (done_evt) m_done = 1;
      else if (st_wr && mmio_wr_data[1]) m_done = 0;
      if (done_evt) m_result = eng_result;
      if (accept) m_busy = 1;
      else if (done_evt) m_busy = 0;
      if (mmio_wr_valid && mmio_addr == 16'h0A) m_src = mmio_wr_data[41:0];
      if (mmio_wr_valid && mmio_addr == 16'h0C) m_dst = mmio_wr_data[41:0];
    end
    @(posedge clk);
    #1;
    if (reset) begin
      check_val("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check_val("rst_rsp_tid", {55'd0, rsp_tid}, 64'd0);
      check_val("rst_rsp_data", rsp_data, 64'd0);
    end else if (rd_exp) begin
      check_val("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check_val("rsp_tid", {55'd0, rsp_tid}, {55'd0, exp_tid_q.pop_front()});
      check_val("rsp_data", rsp_data, exp_q.pop_front());
    end else begin
      check_val("rsp_idle", {63'd0, rsp_valid}, 64'd0);
    end
    check_val("eng_start", {63'd0, eng_start}, {63'd0, m_start});
    check_val("eng_src", {22'd0, eng_src_addr}, {22'd0, m_src});
    check_val("eng_dst", {22'd0, eng_dst_addr}, {22'd0, m_dst});
  endtask

  // driver tasks
  task automatic drive_idle();
    reset = 0; mmio_rd_valid = 0; mmio_wr_valid = 0; mmio_addr = '0;
    mmio_tid = '0; mmio_wr_data = '0; eng_done = 0; eng_result = '0;
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      step();
    end
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [8:0] tid);
    drive_idle();
    mmio_rd_valid = 1; mmio_addr = addr; mmio_tid = tid;
    step();
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [63:0] data);
    drive_idle();
    mmio_wr_valid = 1; mmio_addr = addr; mmio_wr_data = data;
    step();
  endtask

  task automatic do_done(input logic [15:0] res);
    drive_idle();
    eng_done = 1; eng_result = res;
    step();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      reset = 1;
      step();
    end
  endtask

  logic [15:0] addr_tab[11] = '{16'h00, 16'h02, 16'h04, 16'h06, 16'h08, 16'h0A,
                                16'h0C, 16'h0E, 16'h10, 16'h12, 16'h14};

  initial begin
    drive_idle();
    do_reset(2);
    check_val("rst_eng_start", {63'd0, eng_start}, 64'd0);
    do_read(16'h10, 9'd7);
    check_val("rst_status", rsp_data, 64'd0);

    // Header / ID reads, back to back
    drive_idle();
    mmio_rd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      mmio_addr = 16'(2 * i);
      mmio_tid  = 9'(i + 1);
      step();
    end
    do_read(16'h00, 9'd9);
    check_val("dfh_lit", rsp_data, 64'h1000_0100_0000_0000);

    // First job
    do_write(16'h0A, 64'h1000);
    do_write(16'h0C, 64'h2000);
    do_write(16'h0E, 64'h1);
    check_val("start_pulse", {63'd0, eng_start}, 64'd1);
    check_val("src_lit", {22'd0, eng_src_addr}, 64'h1000);
    check_val("dst_lit", {22'd0, eng_dst_addr}, 64'h2000);
    do_read(16'h10, 9'd5);
    check_val("start_single", {63'd0, eng_start}, 64'd0);
    check_val("status_busy", rsp_data, 64'h1);
    do_idle(6);
    do_done(16'h0046);
    do_read(16'h10, 9'd6);
    check_val("status_done", rsp_data, 64'h2);
    do_read(16'h12, 9'd7);
    check_val("result_lit", rsp_data, 64'h46);
    do_read(16'h14, 9'd8);
    check_val("cycles_lit", rsp_data, 64'd8);

    // Overrun: start while busy, and start coinciding with eng_done
    do_write(16'h0E, 64'h1);
    do_idle(2);
    do_write(16'h0E, 64'h1);
    check_val("no_start_busy", {63'd0, eng_start}, 64'd0);
    drive_idle();
    mmio_wr_valid = 1; mmio_addr = 16'h0E; mmio_wr_data = 64'h1;
    eng_done = 1; eng_result = 16'h1234;
    step();
    check_val("no_start_done", {63'd0, eng_start}, 64'd0);
    do_read(16'h10, 9'd10);
    check_val("status_ovr", rsp_data, 64'h6);
    do_write(16'h10, 64'h6);
    do_read(16'h10, 9'd11);
    check_val("status_w1c", rsp_data, 64'h0);

    // eng_done while idle is ignored
    do_done(16'hBEEF);
    do_read(16'h12, 9'd12);
    check_val("idle_done_res", rsp_data, 64'h1234);

    // Reset mid-job, then a stray eng_done, then a fresh start
    do_write(16'h0E, 64'h1);
    do_idle(3);
    do_reset(1);
    do_done(16'h5555);
    do_read(16'h10, 9'd13);
    check_val("post_rst_status", rsp_data, 64'h0);
    do_write(16'h0E, 64'h1);
    check_val("post_rst_start", {63'd0, eng_start}, 64'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int k;
      drive_idle();
      reset = ($urandom_range(0, 199) == 0);
      mmio_rd_valid = ($urandom_range(0, 2) == 0);
      mmio_wr_valid = ($urandom_range(0, 3) == 0);
      k = $urandom_range(0, 11);
      mmio_addr = (k == 11) ? 16'($urandom_range(0, 40)) : addr_tab[k];
      mmio_tid = 9'($urandom);
      mmio_wr_data = {$urandom, $urandom};
      eng_done = ($urandom_range(0, 7) == 0);
      eng_result = 16'($urandom);
      step();
    end
    do_idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
